button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//   Consumes a clean, debounced button level and turns it into one-cycle
//   user-interface event pulses: press, release, click, double-click,
//   long-press and auto-repeat.
//   Sits directly downstream of the synchronous debouncer, in the same clock
//   domain, and feeds menu/control logic that needs gesture events, not levels.
// PARAMETERS
//   CNT_W         16    width of the shared timing counter
//   LONG_TICKS    1000  cycles the button must be held to become a long press
//   DBL_TICKS     250   max cycles from release to second press for a double-click
//   REPEAT_TICKS  100   auto-repeat period while a long press is held
//   Constraint: all *_TICKS >= 2 and <= 2**CNT_W-1.
//   Violating this is a configuration error; no runtime check is made.
// PORTS
//   clk        in   1  system clock
//   rst        in   1  reset, synchronous, active-high
//   btn        in   1  debounced level, 1 = pressed, synchronous to clk
//   press_p    out  1  one-cycle pulse on every 0->1 of btn
//   release_p  out  1  one-cycle pulse on every 1->0 of btn
//   click_p    out  1  single short click confirmed
//   dclick_p   out  1  double-click detected
//   long_p     out  1  hold reached LONG_TICKS
//   repeat_p   out  1  auto-repeat tick during long hold
//   held       out  1  level, high while in LONG state
// BEHAVIOUR
//   Reset state: btn_q=0, state=IDLE, cnt=0, all outputs 0.
//   - After rst deasserts, a btn already high is seen as a rise, so press_p fires.
//   Edge detection: btn_q <= btn; rise = btn & ~btn_q; fall = ~btn & btn_q.
//   - All outputs are registered.
//   - A pulse caused at edge k is high exactly in the cycle after edge k.
//   press_p/release_p: driven by rise/fall in every state, independent of FSM.
//   FSM (cnt cleared on every state change):
//   - IDLE: rise -> PRESS1.
//   - PRESS1: cnt++.
//     - fall -> GAP.
//     - else if cnt==LONG_TICKS-1 -> LONG, and long_p pulses.
//     - Net effect: long_p fires at edge rise+LONG_TICKS only if btn is still 1.
//   - GAP: cnt++.
//     - rise -> WAIT_REL, and dclick_p pulses.
//     - else if cnt==DBL_TICKS-1 -> IDLE, and click_p pulses.
//     - Net effect: click_p fires DBL_TICKS edges after the fall edge.
//   - WAIT_REL: fall -> IDLE. No long/repeat/click events are generated here.
//   - LONG: held=1, cnt++.
//     - fall -> IDLE; no click.
//     - else if cnt==REPEAT_TICKS-1 -> repeat_p pulses, cnt=0.
//   Priority for simultaneous events:
//   - btn edge beats timer expiry: fall beats long_p/repeat_p; rise beats click_p.
//   Exclusivity: click_p, dclick_p, long_p and repeat_p are mutually exclusive
//   in any cycle.
//   - press_p/release_p may coincide with dclick_p.
//   cnt never wraps: every state resets cnt before it can reach 2**CNT_W-1.
//   rst mid-operation: the next cycle is the reset state (held=0, no pulses).
//   - Any partially timed gesture is discarded.
// TESTING  (LONG_TICKS=20, DBL_TICKS=10, REPEAT_TICKS=5)
//   1. Single click: btn=1 for 5 cycles then 0.
//      - press_p one cycle after the rise edge; release_p one cycle after the fall edge.
//      - click_p exactly 10 edges after the fall edge; nothing else.
//   2. Double click: 1 for 5 cycles, 0 for 4, 1 for 3, then 0.
//      - dclick_p together with the 2nd press_p.
//      - No click_p ever; two press_p and two release_p.
//   3. Long hold: btn=1 for 32 cycles.
//      - long_p at rise+20, and held rises with it.
//      - repeat_p at rise+25 and rise+30; held drops after release; no click_p.
//   4. Boundaries:
//      - Fall exactly at rise+20 -> no long_p, click path taken.
//      - Second rise exactly 10 edges after fall -> dclick_p, not click_p.
//      - Fall on the same edge as a repeat expiry -> no repeat_p.
//   5. Reset: assert rst for 1 cycle mid-LONG with btn held 1.
//      - Outputs are 0 and held is 0 in the cycle after reset.
//      - Then press_p (rise seen against btn_q=0), and a new long_p 20 edges later.
//   6. Random btn stream vs behavioural model.
//      - Check pulse exclusivity, one cycle width, and no click within DBL_TICKS of a release.

Source files
------------

// File: rtl/button_event_decoder_if.sv
// Button event bus: the debounced button level going in and the gesture
// event pulses coming out.
//   master : the side that drives btn and consumes events (testbench / upstream)
//   slave  : the decoder itself
interface button_event_decoder_if;
  logic btn;        // debounced level, 1 = pressed
  logic press_p;    // pulse on every 0->1 of btn
  logic release_p;  // pulse on every 1->0 of btn
  logic click_p;    // single short click confirmed
  logic dclick_p;   // double-click detected
  logic long_p;     // hold reached LONG_TICKS
  logic repeat_p;   // auto-repeat tick during long hold
  logic held;       // level, high while in long-hold

  modport master (
    output btn,
    input  press_p, release_p, click_p, dclick_p, long_p, repeat_p, held
  );

  modport slave (
    input  btn,
    output press_p, release_p, click_p, dclick_p, long_p, repeat_p, held
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a clean, debounced button level into one-cycle gesture pulses:
// press, release, click, double-click, long-press and auto-repeat.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  button_event_decoder_if.slave: btn in; press_p, release_p, click_p,
//        dclick_p, long_p, repeat_p, held out (all registered)
// A pulse caused by what is sampled at edge k is high in the cycle after k.
module button_event_decoder #(
  parameter int CNT_W        = 16,
  parameter int LONG_TICKS   = 1000,
  parameter int DBL_TICKS    = 250,
  parameter int REPEAT_TICKS = 100
) (
  input logic                  clk,
  input logic                  rst,
  button_event_decoder_if.slave bus
);

  // Terminal counts; the counter starts at 0 on the edge after a state
  // change, so expiry on cnt == TICKS-1 lands exactly TICKS edges later.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, PRESS1, GAP, WAIT_REL, LONG} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_q;
  logic             rise, fall;

  assign rise = bus.btn & ~btn_q;
  assign fall = ~bus.btn & btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_q         <= 1'b0;
      bus.press_p   <= 1'b0;
      bus.release_p <= 1'b0;
      bus.click_p   <= 1'b0;
      bus.dclick_p  <= 1'b0;
      bus.long_p    <= 1'b0;
      bus.repeat_p  <= 1'b0;
      bus.held      <= 1'b0;
    end else begin
      btn_q         <= bus.btn;
      bus.press_p   <= rise;
      bus.release_p <= fall;
      bus.click_p   <= 1'b0;
      bus.dclick_p  <= 1'b0;
      bus.long_p    <= 1'b0;
      bus.repeat_p  <= 1'b0;

      // Button edges are tested before timer expiry in every state, so an
      // edge always wins over a coincident timeout.
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= '0;
          end
        end
        PRESS1: begin
          if (fall) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            cnt        <= '0;
            bus.long_p <= 1'b1;
            bus.held   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (rise) begin
            state        <= WAIT_REL;
            cnt          <= '0;
            bus.dclick_p <= 1'b1;
          end else if (cnt == DBL_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.click_p <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_REL: begin
          // Second press of a double-click: just wait it out, no timing.
          if (fall) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        LONG: begin
          if (fall) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.held <= 1'b0;
          end else if (cnt == REP_LAST) begin
            cnt          <= '0;
            bus.repeat_p <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed + random bench for button_event_decoder. A timestamp-based model
// predicts the output vector for every edge; predictions are queued when the
// stimulus is driven and popped when the DUT outputs are sampled.
module tb_button_event_decoder;
  localparam int LONG = 20;
  localparam int DBL  = 10;
  localparam int REP  = 5;

  localparam int M_IDLE = 0, M_PRESS = 1, M_GAP = 2, M_WREL = 3, M_LONG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .CNT_W(16), .LONG_TICKS(LONG), .DBL_TICKS(DBL), .REPEAT_TICKS(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // model state
  logic m_q    = 1'b0;
  int   m_mode = M_IDLE;
  int   m_t0   = 0;

  // scoreboard: {held, repeat, long, dclick, click, release, press}
  logic [6:0] sb_q[$];
  logic [6:0] obs, prev_obs, last_obs;

  // per-phase event log
  int n_press, n_rel, n_click, n_dclick, n_long, n_rep, n_held;
  int e_press, e_rel, e_click, e_dclick, e_long, first_rep, last_rep, first_held;
  int last_rel_g = -1000;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    assert (got === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_click = 0; n_dclick = 0; n_long = 0; n_rep = 0; n_held = 0;
    e_press = -1; e_rel = -1; e_click = -1; e_dclick = -1; e_long = -1;
    first_rep = -1; last_rep = -1; first_held = -1;
  endtask

  // Predict the outputs after the coming edge, using elapsed time since the
  // edge that started the current phase.
  task automatic model(input logic b, input logic r);
    logic [6:0] w;
    logic rise, fall;
    w = '0;
    if (r) begin
      m_q = 1'b0;
      m_mode = M_IDLE;
    end else begin
      rise = b & ~m_q;
      fall = ~b & m_q;
      m_q  = b;
      w[0] = rise;
      w[1] = fall;
      case (m_mode)
        M_IDLE:  if (rise) begin m_mode = M_PRESS; m_t0 = cyc; end
        M_PRESS: if (fall) begin m_mode = M_GAP; m_t0 = cyc; end
                 else if (cyc - m_t0 == LONG) begin m_mode = M_LONG; m_t0 = cyc; w[4] = 1'b1; end
        M_GAP:   if (rise) begin m_mode = M_WREL; w[3] = 1'b1; end
                 else if (cyc - m_t0 == DBL) begin m_mode = M_IDLE; w[2] = 1'b1; end
        M_WREL:  if (fall) m_mode = M_IDLE;
        M_LONG:  if (fall) m_mode = M_IDLE;
                 else if ((cyc - m_t0) % REP == 0) w[5] = 1'b1;
        default: m_mode = M_IDLE;
      endcase
      w[6] = (m_mode == M_LONG);
    end
    sb_q.push_back(w);
  endtask

  task automatic step(input logic b, input logic r);
    logic [6:0] want;
    bus.btn = b;
    rst     = r;
    cyc++;
    model(b, r);
    @(posedge clk);
    #1;
    obs = {bus.held, bus.repeat_p, bus.long_p, bus.dclick_p, bus.click_p,
           bus.release_p, bus.press_p};
    want = sb_q.pop_front();
    chk("vec", int'(obs), int'(want));
    chk("excl", ($countones(obs[5:2]) <= 1) ? 1 : 0, 1);
    chk("width", int'(prev_obs[5:0] & obs[5:0]), 0);
    if (obs[1]) last_rel_g = cyc;
    if (obs[2]) chk("click_win", (cyc - last_rel_g >= DBL) ? 1 : 0, 1);
    if (obs[0]) begin n_press++;  e_press  = cyc; end
    if (obs[1]) begin n_rel++;    e_rel    = cyc; end
    if (obs[2]) begin n_click++;  e_click  = cyc; end
    if (obs[3]) begin n_dclick++; e_dclick = cyc; end
    if (obs[4]) begin n_long++;   e_long   = cyc; end
    if (obs[5]) begin
      if (n_rep == 0) first_rep = cyc;
      last_rep = cyc;
      n_rep++;
    end
    if (obs[6]) begin
      if (n_held == 0) first_held = cyc;
      n_held++;
    end
    prev_obs = obs;
    last_obs = obs;
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int r, f, r2, x, len;
    logic b;
    bus.btn  = 1'b0;
    prev_obs = '0;
    clr();

    // reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_out", int'(last_obs), 0);
    run(1'b0, 3);

    // 1. single click
    clr();
    r = cyc + 1; run(1'b1, 5);
    f = cyc + 1; run(1'b0, 15);
    chk("p1_press_at", e_press, r);
    chk("p1_rel_at", e_rel, f);
    chk("p1_click_at", e_click, f + DBL);
    chk("p1_n_click", n_click, 1);
    chk("p1_others", n_dclick + n_long + n_rep, 0);

    // 2. double click
    clr();
    run(1'b1, 5); run(1'b0, 4);
    r2 = cyc + 1; run(1'b1, 3); run(1'b0, 15);
    chk("p2_dclick_at", e_dclick, r2);
    chk("p2_n_press", n_press, 2);
    chk("p2_n_rel", n_rel, 2);
    chk("p2_n_click", n_click, 0);

    // 3. long hold
    clr();
    r = cyc + 1; run(1'b1, 32); run(1'b0, 15);
    chk("p3_long_at", e_long, r + LONG);
    chk("p3_held_rise", first_held, r + LONG);
    chk("p3_held_len", n_held, 12);
    chk("p3_rep_first", first_rep, r + LONG + REP);
    chk("p3_rep_last", last_rep, r + LONG + 2 * REP);
    chk("p3_n_rep", n_rep, 2);
    chk("p3_n_click", n_click, 0);

    // 4a. fall exactly at rise+LONG
    clr();
    r = cyc + 1; run(1'b1, LONG);
    f = cyc + 1; run(1'b0, 15);
    chk("p4a_n_long", n_long, 0);
    chk("p4a_click_at", e_click, f + DBL);

    // 4b. second rise exactly DBL edges after fall
    clr();
    run(1'b1, 3);
    f = cyc + 1; run(1'b0, DBL);
    r2 = cyc + 1; run(1'b1, 2); run(1'b0, 15);
    chk("p4b_dclick_at", e_dclick, f + DBL);
    chk("p4b_n_click", n_click, 0);

    // 4c. fall coincides with a repeat expiry
    clr();
    r = cyc + 1; run(1'b1, LONG + 2 * REP); run(1'b0, 15);
    chk("p4c_n_long", n_long, 1);
    chk("p4c_n_rep", n_rep, 1);
    chk("p4c_rep_at", first_rep, r + LONG + REP);
    chk("p4c_n_click", n_click, 0);

    // 5. reset mid-LONG with btn held
    clr();
    run(1'b1, LONG + 5);
    chk("p5_held_pre", int'(last_obs[6]), 1);
    x = cyc + 1;
    step(1'b1, 1'b1);
    chk("p5_rst_out", int'(last_obs), 0);
    clr();
    run(1'b1, 25);
    chk("p5_press_at", e_press, x + 1);
    chk("p5_long_at", e_long, x + 1 + LONG);
    run(1'b0, 15);

    // 6. random stream
    b = 1'b0;
    for (int k = 0; k < 80; k++) begin
      b   = ~b;
      len = $urandom_range(1, 30);
      run(b, len);
    end
    run(1'b0, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
